// File: rtl/mdsp_dac_out_pkg.sv
// Shared constants and helpers for the DSP-to-DAC output stage.
// Optional dither is enabled by defining MDSP_DAC_OUT_DITHER_EN.
package mdsp_dac_out_pkg;

  localparam int unsigned DAC_BITS_DEF = 16;
  localparam int unsigned SAT_W        = 32;

  // Fibonacci LFSR, polynomial x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // Clamp a signed value into the range of a 'bits'-wide two's complement word
  function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] v,
                                                       input int unsigned bits);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (32'sd1 <<< (bits - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/mdsp_dac_out_if.sv
// Sample stream from the DSP core into the DAC output stage.
interface mdsp_dac_out_if #(
  parameter int unsigned g_in_bits = 24
);
  logic                        y_valid_i;
  logic signed [g_in_bits-1:0] y_i;
  logic                        y_req_o;

  modport master (output y_valid_i, output y_i, input y_req_o);
  modport slave  (input y_valid_i, input y_i, output y_req_o);
endinterface

// File: rtl/mdsp_dac_out_sfifo.sv
// Synchronous FIFO with first-word fall-through: a word pushed in cycle N
// is visible on dout_o and poppable from cycle N+1.
module mdsp_sfifo #(
  parameter int unsigned g_width = 24,
  parameter int unsigned g_depth = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [g_width-1:0]         din_i,
  output logic [g_width-1:0]         dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(g_depth):0]   level_o
);
  localparam int unsigned AW = $clog2(g_depth);

  logic [g_width-1:0] mem [g_depth];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [AW:0]        count;

  // Storage array, no reset needed
  always_ff @(posedge clk_i) begin
    if (push_i) mem[wr_ptr] <= din_i;
  end

  // Pointers and fill count; reset discards contents
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_i) wr_ptr <= wr_ptr + 1'b1;
      if (pop_i)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign dout_o  = mem[rd_ptr];
  assign full_o  = (count == (AW+1)'(g_depth));
  assign empty_o = (count == '0);
  assign level_o = count;

endmodule

// File: rtl/mdsp_dac_out.sv
// DAC output stage: buffers DSP samples, pops one per rate tick, scales and
// saturates to DAC width and strobes the registered word out.
// Build option: MDSP_DAC_OUT_DITHER_EN adds LFSR dither before the shift.
module mdsp_dac_out
  import mdsp_dac_out_pkg::*;
#(
  parameter int unsigned g_in_bits       = 24,
  parameter int unsigned g_dac_bits      = DAC_BITS_DEF,
  parameter int unsigned g_shift         = 6,
  parameter int unsigned g_fifo_depth    = 16,
  parameter int unsigned g_div_bits      = 16,
  parameter bit          g_offset_binary = 1'b1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  mdsp_dac_out_if.slave                    y_if,
  input  logic                             en_i,
  input  logic [g_div_bits-1:0]            rate_div_i,
  input  logic                             clr_flags_i,
  output logic [g_dac_bits-1:0]            dac_data_o,
  output logic                             dac_strobe_o,
  output logic                             ovf_o,
  output logic                             unf_o,
  output logic [$clog2(g_fifo_depth):0]    level_o
);
  localparam int unsigned LW = $clog2(g_fifo_depth) + 1;
  localparam logic [g_dac_bits-1:0] MID =
    g_offset_binary ? {1'b1, {(g_dac_bits-1){1'b0}}} : '0;

  logic [g_div_bits-1:0]       cnt;
  logic                        tick, push, pop, full, empty;
  logic                        ovf_evt, unf_evt;
  logic [LW-1:0]               level;
  logic [g_in_bits-1:0]        head;
  logic [g_in_bits:0]          sum;
  logic signed [g_in_bits:0]   shifted;
  logic signed [SAT_W-1:0]     sat;
  logic [g_dac_bits-1:0]       word;

  mdsp_sfifo #(.g_width(g_in_bits), .g_depth(g_fifo_depth)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (y_if.y_i),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .level_o (level)
  );

  // One slot held back for the sample the core already has in flight
  assign y_if.y_req_o = !rst_i && (level < LW'(g_fifo_depth - 1));
  assign level_o      = level;

  // Tick and handshake decode; a pop in the same cycle frees a slot for a push when full
  always_comb begin
    tick    = en_i && ((rate_div_i <= g_div_bits'(1)) || (cnt >= rate_div_i - 1'b1));
    pop     = tick && !empty;
    push    = y_if.y_valid_i && (!full || pop);
    ovf_evt = y_if.y_valid_i && full && !pop;
    unf_evt = tick && empty;
  end

  // Rate divider counter
  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i || tick) cnt <= '0;
    else                        cnt <= cnt + 1'b1;
  end

`ifdef MDSP_DAC_OUT_DITHER_EN
  localparam logic [15:0] DMASK = 16'((32'd1 << g_shift) - 32'd1);
  logic [15:0] lfsr;

  // Dither source advances once per popped sample
  always_ff @(posedge clk_i) begin
    if (rst_i)    lfsr <= LFSR_SEED;
    else if (pop) lfsr <= lfsr_next(lfsr);
  end

  // Widen by one bit so dither cannot wrap a full-scale sample
  always_comb begin
    sum = {head[g_in_bits-1], head} + {{(g_in_bits-15){1'b0}}, lfsr & DMASK};
  end
`else
  // Plain truncation: sign-extend only
  always_comb begin
    sum = {head[g_in_bits-1], head};
  end
`endif

  // Shift, saturate to DAC range, apply output coding
  always_comb begin
    shifted = $signed(sum) >>> g_shift;
    sat     = saturate(SAT_W'(shifted), g_dac_bits);
    word    = sat[g_dac_bits-1:0] ^ MID;
  end

  // DAC word register; an empty tick still strobes and repeats the last word
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dac_data_o   <= MID;
      dac_strobe_o <= 1'b0;
    end else if (!en_i) begin
      dac_data_o   <= MID;
      dac_strobe_o <= 1'b0;
    end else begin
      dac_strobe_o <= tick;
      if (pop) dac_data_o <= word;
    end
  end

  // Sticky flags; a new event outranks a simultaneous clear
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf_o <= 1'b0;
      unf_o <= 1'b0;
    end else begin
      ovf_o <= ovf_evt || (ovf_o && !clr_flags_i);
      unf_o <= unf_evt || (unf_o && !clr_flags_i);
    end
  end

endmodule

// File: tb/tb_mdsp_dac_out.sv
// Directed bench for mdsp_dac_out with an expected-word scoreboard.
module tb_mdsp_dac_out;

  logic        clk = 1'b0;
  logic        rst, en, clr;
  logic [15:0] rate_div;
  logic [15:0] dac;
  logic        strobe, ovf, unf;
  logic [4:0]  level;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] sb[$];
  int          cyc_no = 0;
  int          last_strb = -1;
  int          prev_strb = -1;
  bit          dither_tol = 1'b0;

`ifdef MDSP_DAC_OUT_DITHER_EN
  localparam bit DITHER = 1'b1;
`else
  localparam bit DITHER = 1'b0;
`endif

  always #5 clk = ~clk;

  mdsp_dac_out_if #(.g_in_bits(24)) y_if ();

  mdsp_dac_out #(
    .g_in_bits(24), .g_dac_bits(16), .g_shift(6), .g_fifo_depth(16),
    .g_div_bits(16), .g_offset_binary(1'b1)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .y_if         (y_if),
    .en_i         (en),
    .rate_div_i   (rate_div),
    .clr_flags_i  (clr),
    .dac_data_o   (dac),
    .dac_strobe_o (strobe),
    .ovf_o        (ovf),
    .unf_o        (unf),
    .level_o      (level)
  );

  // Reference: arithmetic shift by 6, clamp to 16-bit signed, offset binary
  function automatic logic [15:0] ref_word(input int y);
    int s;
    s = y >>> 6;
    if (s > 32767)  s = 32767;
    if (s < -32768) s = -32768;
    return 16'(s) ^ 16'h8000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock, sample after the edge, score any strobe
  task automatic cyc();
    logic [15:0] exp;
    @(posedge clk);
    #1;
    cyc_no++;
    if (strobe === 1'b1) begin
      prev_strb = last_strb;
      last_strb = cyc_no;
      if (sb.size() == 0) begin
        chk("spurious_strobe", {31'b0, strobe}, 32'd0);
      end else begin
        exp = sb.pop_front();
        if (dither_tol && DITHER && dac === exp + 16'd1) exp = exp + 16'd1;
        chk("dac_word", {16'b0, dac}, {16'b0, exp});
      end
    end
  endtask

  task automatic push(input int y, input bit accepted);
    y_if.y_valid_i = 1'b1;
    y_if.y_i       = 24'(y);
    if (accepted) sb.push_back(ref_word(y));
    cyc();
    y_if.y_valid_i = 1'b0;
  endtask

  task automatic run_en(input int n);
    en = 1'b1;
    repeat (n) cyc();
    en = 1'b0;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; rate_div = 16'd4;
    y_if.y_valid_i = 1'b0; y_if.y_i = '0;
    repeat (3) cyc();
    chk("reset_dac", {16'b0, dac}, 32'h8000);
    chk("reset_strobe", {31'b0, strobe}, 32'd0);
    chk("reset_ovf", {31'b0, ovf}, 32'd0);
    chk("reset_unf", {31'b0, unf}, 32'd0);
    chk("reset_level", {27'b0, level}, 32'd0);
    chk("reset_req", {31'b0, y_if.y_req_o}, 32'd0);
    rst = 1'b0;
    cyc();
    chk("req_after_reset", {31'b0, y_if.y_req_o}, 32'd1);

    // Two samples at rate 4: strobes four cycles apart
    push(6400, 1'b1);
    push(-64, 1'b1);
    rate_div = 16'd4;
    run_en(8);
    chk("strobe_gap", 32'(last_strb - prev_strb), 32'd4);
    cyc();
    chk("midscale_when_disabled", {16'b0, dac}, 32'h8000);
    chk("level_after_drain", {27'b0, level}, 32'd0);

    // Saturation at both ends
    push(32'h007FFFFF, 1'b1);
    push(-8388608, 1'b1);
    run_en(8);

    // Fill with output halted: request drops at 15, 17th sample overflows
    for (int i = 0; i < 15; i++) begin
      if (i == 14) begin
        chk("level_14", {27'b0, level}, 32'd14);
        chk("req_at_14", {31'b0, y_if.y_req_o}, 32'd1);
      end
      push(i * 6400 - 40000, 1'b1);
    end
    chk("level_15", {27'b0, level}, 32'd15);
    chk("req_at_15", {31'b0, y_if.y_req_o}, 32'd0);
    push(123456, 1'b1);
    chk("ovf_before_drop", {31'b0, ovf}, 32'd0);
    chk("level_full", {27'b0, level}, 32'd16);
    push(-123456, 1'b0);
    chk("ovf_on_drop", {31'b0, ovf}, 32'd1);
    chk("level_still_full", {27'b0, level}, 32'd16);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("ovf_cleared", {31'b0, ovf}, 32'd0);
    rate_div = 16'd1;
    run_en(16);
    chk("level_drained", {27'b0, level}, 32'd0);
    chk("no_unf_exact_drain", {31'b0, unf}, 32'd0);

    // Single sample at rate 2: second tick repeats the word and flags underflow
    rate_div = 16'd2;
    push(320000, 1'b1);
    sb.push_back(ref_word(320000));
    run_en(4);
    chk("unf_set", {31'b0, unf}, 32'd1);
    clr = 1'b1; en = 1'b1; rate_div = 16'd1;
    sb.push_back(ref_word(320000));
    cyc();
    chk("unf_event_beats_clear", {31'b0, unf}, 32'd1);
    en = 1'b0;
    cyc();
    clr = 1'b0;
    chk("unf_cleared", {31'b0, unf}, 32'd0);
    chk("midscale_after_halt", {16'b0, dac}, 32'h8000);

    // Reset mid-run with eight samples buffered
    for (int i = 0; i < 9; i++) push(i * 1000 + 64, 1'b1);
    rate_div = 16'd1;
    en = 1'b1;
    cyc();
    chk("level_before_reset", {27'b0, level}, 32'd8);
    sb.delete();
    rst = 1'b1; en = 1'b0;
    cyc();
    chk("rst_level", {27'b0, level}, 32'd0);
    chk("rst_dac", {16'b0, dac}, 32'h8000);
    chk("rst_strobe", {31'b0, strobe}, 32'd0);
    chk("rst_req", {31'b0, y_if.y_req_o}, 32'd0);
    rst = 1'b0;
    cyc();

    // Streaming 1000 samples of 6400 (dither may add one LSB)
    push(6400, 1'b1);
    dither_tol = 1'b1;
    en = 1'b1; rate_div = 16'd1;
    y_if.y_valid_i = 1'b1; y_if.y_i = 24'd6400;
    repeat (999) begin
      sb.push_back(ref_word(6400));
      cyc();
    end
    y_if.y_valid_i = 1'b0;
    cyc();
    en = 1'b0;
    dither_tol = 1'b0;
    cyc();
    chk("stream_level", {27'b0, level}, 32'd0);
    chk("stream_no_ovf", {31'b0, ovf}, 32'd0);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
